// File: rtl/input_stage_flt_if.sv
// rtl/input_stage_flt_if.sv - control, config, signal and event bundle for input_stage_flt
interface input_stage_flt_if #(
    parameter int EXTSIG_NUM = 32,
    parameter int SEL_W      = 8,
    parameter int FILT_W     = 4,
    parameter int DIV_W      = 8
);
    logic                  ctrl_active_i;
    logic                  ctrl_update_i;
    logic                  ctrl_arm_i;
    logic                  cnt_end_i;
    logic [SEL_W-1:0]      cfg_sel_i;
    logic                  cfg_sel_clk_i;
    logic [2:0]            cfg_mode_i;
    logic [FILT_W-1:0]     cfg_filt_i;
    logic [DIV_W-1:0]      cfg_div_i;
    logic                  ls_clk_i;
    logic [EXTSIG_NUM-1:0] signal_i;
    logic                  event_o;
    logic                  filt_sig_o;
    logic [DIV_W-1:0]      div_cnt_o;

    modport master (
        output ctrl_active_i, ctrl_update_i, ctrl_arm_i, cnt_end_i,
        output cfg_sel_i, cfg_sel_clk_i, cfg_mode_i, cfg_filt_i, cfg_div_i,
        output ls_clk_i, signal_i,
        input  event_o, filt_sig_o, div_cnt_o
    );

    modport slave (
        input  ctrl_active_i, ctrl_update_i, ctrl_arm_i, cnt_end_i,
        input  cfg_sel_i, cfg_sel_clk_i, cfg_mode_i, cfg_filt_i, cfg_div_i,
        input  ls_clk_i, signal_i,
        output event_o, filt_sig_o, div_cnt_o
    );
endinterface

// File: rtl/input_stage_flt.sv
// rtl/input_stage_flt.sv - external signal select, glitch filter, edge prescaler and event modes
module input_stage_flt #(
    parameter int EXTSIG_NUM = 32,
    parameter int SEL_W      = 8,
    parameter int FILT_W     = 4,
    parameter int DIV_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input_stage_flt_if.slave      bus
);

    typedef enum logic [2:0] {
        MODE_STROBE  = 3'b000,
        MODE_LOW     = 3'b001,
        MODE_HIGH    = 3'b010,
        MODE_RISE    = 3'b011,
        MODE_FALL    = 3'b100,
        MODE_BOTH    = 3'b101,
        MODE_RISE_OS = 3'b110,
        MODE_FALL_OS = 3'b111
    } mode_e;

    logic [2:0]        sync_q,  sync_d;
    mode_e             mode_q,  mode_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [FILT_W-1:0] flen_q,  flen_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic              filt_q,  filt_d;
    logic [FILT_W-1:0] fcnt_q,  fcnt_d;
    logic [DIV_W-1:0]  dcnt_q,  dcnt_d;
    logic              armed_q, armed_d;
    logic              latch_q, latch_d;

    logic ls_rise;
    logic strobe;
    logic raw;
    logic step_en;
    logic upd;
    logic rise;
    logic fall;
    logic qedge;
    logic fire;
    logic event_c;

    always_comb begin
        sync_d  = {sync_q[1:0], bus.ls_clk_i};
        mode_d  = mode_q;
        sel_d   = sel_q;
        flen_d  = flen_q;
        div_d   = div_q;
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        armed_d = armed_q;
        latch_d = latch_q;
        raw     = 1'b0;
        qedge   = 1'b0;
        event_c = 1'b0;

        ls_rise = ~sync_q[2] & sync_q[1];
        strobe  = bus.cfg_sel_clk_i ? ls_rise : 1'b1;

        // Out-of-range selects match no index and leave raw at 0
        for (int i = 0; i < EXTSIG_NUM; i++) begin
            if (sel_q == SEL_W'(i)) begin
                raw = bus.signal_i[i];
            end
        end

        // A config load owns the filter/prescaler counters for that cycle
        step_en = bus.ctrl_active_i & strobe & ~bus.ctrl_update_i;
        upd     = step_en & (raw != filt_q) & (fcnt_q == flen_q);
        rise    = upd & raw;
        fall    = upd & ~raw;

        case (mode_q)
            MODE_RISE, MODE_RISE_OS: qedge = rise;
            MODE_FALL, MODE_FALL_OS: qedge = fall;
            MODE_BOTH:               qedge = rise | fall;
            default:                 qedge = 1'b0;
        endcase

        fire = qedge & ~bus.ctrl_update_i & (dcnt_q == div_q);

        if (bus.ctrl_update_i) begin
            mode_d = mode_e'(bus.cfg_mode_i);
            sel_d  = bus.cfg_sel_i;
            flen_d = bus.cfg_filt_i;
            div_d  = bus.cfg_div_i;
            fcnt_d = '0;
            dcnt_d = '0;
        end else begin
            if (step_en) begin
                if (raw == filt_q) begin
                    fcnt_d = '0;
                end else if (upd) begin
                    filt_d = raw;
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fcnt_q + FILT_W'(1);
                end
            end
            if (qedge) begin
                dcnt_d = fire ? '0 : dcnt_q + DIV_W'(1);
            end
        end

        // Arm beats counter-end on armed, but counter-end still clears the latch
        if (bus.cnt_end_i) begin
            latch_d = 1'b0;
        end else if (armed_q & fire) begin
            latch_d = 1'b1;
        end
        if (bus.ctrl_arm_i) begin
            armed_d = 1'b1;
        end else if (bus.cnt_end_i) begin
            armed_d = 1'b0;
        end

        case (mode_q)
            MODE_STROBE:               event_c = strobe;
            MODE_LOW:                  event_c = ~filt_q & strobe;
            MODE_HIGH:                 event_c = filt_q & strobe;
            MODE_RISE, MODE_FALL,
            MODE_BOTH:                 event_c = fire;
            MODE_RISE_OS, MODE_FALL_OS: event_c = armed_q & (fire | latch_q);
            default:                   event_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q  <= '0;
            mode_q  <= MODE_STROBE;
            sel_q   <= '0;
            flen_q  <= '0;
            div_q   <= '0;
            filt_q  <= 1'b0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
            armed_q <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            flen_q  <= flen_d;
            div_q   <= div_d;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
            armed_q <= armed_d;
            latch_q <= latch_d;
        end
    end

    assign bus.event_o    = event_c;
    assign bus.filt_sig_o = filt_q;
    assign bus.div_cnt_o  = dcnt_q;

endmodule

// File: tb/tb_input_stage_flt.sv
// tb/tb_input_stage_flt.sv - directed self-checking bench for input_stage_flt
module tb_input_stage_flt;

    logic clk;
    logic rstn;
    int   pass_cnt;
    int   total_cnt;

    input_stage_flt_if bus_if ();

    input_stage_flt dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [2:0] mode, input logic [7:0] sel,
                            input logic [3:0] filt, input logic [7:0] div);
        bus_if.cfg_mode_i    = mode;
        bus_if.cfg_sel_i     = sel;
        bus_if.cfg_filt_i    = filt;
        bus_if.cfg_div_i     = div;
        bus_if.ctrl_update_i = 1'b1;
        step();
        bus_if.ctrl_update_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL reset_event got %b want 1", bus_if.event_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL reset_filt got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.div_cnt_o !== 8'd0) $display("FAIL reset_div got %0d want 0", bus_if.div_cnt_o);
        else pass_cnt++;
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_edge_filt0();
        bus_if.ctrl_active_i = 1'b1;
        load_cfg(3'b011, 8'd3, 4'd0, 8'd0);
        bus_if.signal_i[3] = 1'b1;
        #1;
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL edge0_event_first got %b want 1", bus_if.event_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL edge0_filt_first got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL edge0_event_second got %b want 0", bus_if.event_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b1) $display("FAIL edge0_filt_second got %b want 1", bus_if.filt_sig_o);
        else pass_cnt++;
        bus_if.signal_i[3] = 1'b0;
        #1;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL edge0_fall_event got %b want 0", bus_if.event_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL edge0_fall_filt got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
    endtask

    task automatic test_filter();
        load_cfg(3'b010, 8'd5, 4'd3, 8'd0);
        bus_if.signal_i[5] = 1'b1;
        step(); step(); step();
        bus_if.signal_i[5] = 1'b0;
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL filt_glitch3 got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL filt_glitch_after got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL filt_glitch_event got %b want 0", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i[5] = 1'b1;
        step(); step(); step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL filt_hold3 got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b1) $display("FAIL filt_hold4 got %b want 1", bus_if.filt_sig_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL filt_high_event got %b want 1", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i[5] = 1'b0;
        step(); step(); step(); step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL filt_release got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
    endtask

    task automatic test_prescaler();
        logic       exp_ev;
        logic [7:0] exp_cnt;
        load_cfg(3'b101, 8'd7, 4'd0, 8'd2);
        for (int k = 1; k <= 6; k++) begin
            exp_ev  = (k % 3 == 0);
            exp_cnt = 8'(k % 3);
            bus_if.signal_i[7] = ~bus_if.signal_i[7];
            #1;
            total_cnt++;
            if (bus_if.event_o !== exp_ev)
                $display("FAIL presc_event edge %0d got %b want %b", k, bus_if.event_o, exp_ev);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus_if.div_cnt_o !== exp_cnt)
                $display("FAIL presc_count edge %0d got %0d want %0d", k, bus_if.div_cnt_o, exp_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_one_shot();
        load_cfg(3'b110, 8'd9, 4'd0, 8'd0);
        bus_if.ctrl_arm_i = 1'b1;
        step();
        bus_if.ctrl_arm_i = 1'b0;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL os_armed_idle got %b want 0", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i[9] = 1'b1;
        #1;
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL os_fire got %b want 1", bus_if.event_o);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL os_held got %b want 1", bus_if.event_o);
        else pass_cnt++;
        bus_if.cnt_end_i = 1'b1;
        step();
        bus_if.cnt_end_i = 1'b0;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL os_cnt_end got %b want 0", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i[9] = 1'b0;
        step();
        bus_if.signal_i[9] = 1'b1;
        #1;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL os_disarmed_rise got %b want 0", bus_if.event_o);
        else pass_cnt++;
        step();
        bus_if.ctrl_arm_i = 1'b1;
        step();
        bus_if.ctrl_arm_i = 1'b0;
        bus_if.signal_i[9] = 1'b0;
        step();
        bus_if.signal_i[9] = 1'b1;
        step();
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL os_rearm_latch got %b want 1", bus_if.event_o);
        else pass_cnt++;
        bus_if.ctrl_arm_i = 1'b1;
        bus_if.cnt_end_i  = 1'b1;
        step();
        bus_if.ctrl_arm_i = 1'b0;
        bus_if.cnt_end_i  = 1'b0;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL os_arm_end_latch got %b want 0", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i[9] = 1'b0;
        step();
        bus_if.signal_i[9] = 1'b1;
        #1;
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL os_arm_end_armed got %b want 1", bus_if.event_o);
        else pass_cnt++;
        bus_if.cnt_end_i = 1'b1;
        step();
        bus_if.cnt_end_i = 1'b0;
        bus_if.signal_i[9] = 1'b0;
        step();
    endtask

    task automatic test_ls_clk();
        logic exp_ev;
        logic exp_filt;
        load_cfg(3'b000, 8'd11, 4'd0, 8'd0);
        bus_if.cfg_sel_clk_i = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 1; k <= 10; k++) begin
                if (k == 1) bus_if.ls_clk_i = 1'b1;
                if (k == 6) bus_if.ls_clk_i = 1'b0;
                if (p == 1 && k == 4) bus_if.signal_i[11] = 1'b1;
                if (p == 1 && k == 7) bus_if.signal_i[11] = 1'b0;
                if (p == 2 && k == 1) bus_if.signal_i[11] = 1'b1;
                step();
                exp_ev   = (k == 2);
                exp_filt = (p == 2 && k >= 3);
                total_cnt++;
                if (bus_if.event_o !== exp_ev)
                    $display("FAIL ls_event p%0d k%0d got %b want %b", p, k, bus_if.event_o, exp_ev);
                else pass_cnt++;
                total_cnt++;
                if (bus_if.filt_sig_o !== exp_filt)
                    $display("FAIL ls_filt p%0d k%0d got %b want %b", p, k, bus_if.filt_sig_o, exp_filt);
                else pass_cnt++;
            end
        end
        bus_if.cfg_sel_clk_i = 1'b0;
        bus_if.signal_i[11]  = 1'b0;
        step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL ls_restore got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
    endtask

    task automatic test_sel_oob();
        bus_if.signal_i = '1;
        load_cfg(3'b010, 8'd40, 4'd0, 8'd0);
        step(); step(); step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL oob_filt got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL oob_event got %b want 0", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i = '0;
        step();
    endtask

    task automatic test_async_reset();
        load_cfg(3'b101, 8'd2, 4'd0, 8'd3);
        bus_if.signal_i[2] = 1'b1;
        #1;
        total_cnt++;
        if (bus_if.event_o !== 1'b0) $display("FAIL ar_pre_event got %b want 0", bus_if.event_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b1) $display("FAIL ar_pre_filt got %b want 1", bus_if.filt_sig_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.div_cnt_o !== 8'd1) $display("FAIL ar_pre_div got %0d want 1", bus_if.div_cnt_o);
        else pass_cnt++;
        #2;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (bus_if.filt_sig_o !== 1'b0) $display("FAIL ar_filt got %b want 0", bus_if.filt_sig_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.div_cnt_o !== 8'd0) $display("FAIL ar_div got %0d want 0", bus_if.div_cnt_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.event_o !== 1'b1) $display("FAIL ar_event got %b want 1", bus_if.event_o);
        else pass_cnt++;
        bus_if.signal_i = '0;
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rstn                 = 1'b1;
        bus_if.ctrl_active_i = 1'b0;
        bus_if.ctrl_update_i = 1'b0;
        bus_if.ctrl_arm_i    = 1'b0;
        bus_if.cnt_end_i     = 1'b0;
        bus_if.cfg_sel_i     = '0;
        bus_if.cfg_sel_clk_i = 1'b0;
        bus_if.cfg_mode_i    = '0;
        bus_if.cfg_filt_i    = '0;
        bus_if.cfg_div_i     = '0;
        bus_if.ls_clk_i      = 1'b0;
        bus_if.signal_i      = '0;
        #1 rstn = 1'b0;

        test_reset();
        test_edge_filt0();
        test_filter();
        test_prescaler();
        test_one_shot();
        test_ls_clk();
        test_sel_oob();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/input_stage_flt.md
Name: input_stage_flt

Overview:
- Parametrised successor to the timer input stage: selects one of EXTSIG_NUM external signals and samples it on every clock or on synchronised ls_clk rising edges.
- Adds a programmable glitch filter and an edge-event prescaler, so only every (div+1)-th qualified edge fires.
- Keeps the armed/latched one-shot modes.
- Sits between the external signal bus and the timer counter trigger logic; event_o drives counter start/advance.

Parameters:
EXTSIG_NUM, 32, number of selectable external signals
SEL_W, 8, width of the signal-select field
FILT_W, 4, width of the glitch-filter length field
DIV_W, 8, width of the edge-prescaler field

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
ctrl_active_i  in  1  enables filter/sampling update
ctrl_update_i  in  1  load shadow config from cfg_* inputs
ctrl_arm_i  in  1  arm one-shot modes
cnt_end_i  in  1  counter end; disarms and clears latch
cfg_sel_i  in  SEL_W  signal index
cfg_sel_clk_i  in  1  1 = sample on ls_clk rise, 0 = every clk (not shadowed)
cfg_mode_i  in  3  event mode
cfg_filt_i  in  FILT_W  filter length
cfg_div_i  in  DIV_W  edge prescale value
ls_clk_i  in  1  asynchronous low-speed clock
signal_i  in  EXTSIG_NUM  external signals
event_o  out  1  event to counter
filt_sig_o  out  1  filtered signal level
div_cnt_o  out  DIV_W  current prescaler count

Behaviour:
Reset:
- All registers are 0, including the shadow regs, filter state, counters, armed and latch.
- event_o = 0 in modes 001–111. In mode 000 with cfg_sel_clk_i = 0, event_o = 1 out of reset.
- filt_sig_o = 0, div_cnt_o = 0.

Config:
- ctrl_update_i latches mode, sel, filt and div into shadows.
- The same ctrl_update_i cycle clears the filter counter and the prescaler count. It does not change the filtered level.

Sampling:
- ls_clk_i passes through a 3-FF synchroniser. ls_rise = ~sync[2] & sync[1].
- strobe = cfg_sel_clk_i ? ls_rise : 1.

Selection:
- raw = signal_i[sel] when sel < EXTSIG_NUM, else raw = 0.

Filter (update only when ctrl_active_i & strobe):
- raw == filt: fcnt <= 0.
- raw != filt and fcnt == filt_len: filt <= raw, fcnt <= 0. This is the update pulse upd.
- Otherwise: fcnt <= fcnt + 1.
- Effect: a change must be seen on filt_len+1 consecutive strobes. filt_len = 0 means the level updates on the first strobe.
- A glitch shorter than that restarts fcnt and is lost.
- When inactive, filt and fcnt hold.

Edges (combinational, 1 cycle wide):
- rise = upd & raw.
- fall = upd & ~raw.
- qualified edge q per mode: rise in 011/110, fall in 100/111, rise|fall in 101.

Prescaler:
- On q: if dcnt == div then dcnt <= 0 and fire = 1, else dcnt <= dcnt + 1.
- div = 0 means every edge fires.
- Wraps at div, so no overflow is possible.

Modes (event_o):
- 000: strobe
- 001: ~filt & strobe
- 010: filt & strobe
- 011/100/101: fire
- 110/111: armed & (fire | latch)

One-shot:
- ctrl_arm_i sets armed. cnt_end_i clears armed and latch.
- If ctrl_arm_i and cnt_end_i are high in the same cycle, arm wins and latch is cleared.
- While armed, fire sets latch. event_o stays high from the fire cycle until cnt_end_i.
- When not armed, edges still advance dcnt but event_o = 0.

Output timing:
- filt_sig_o = filt register.
- div_cnt_o = dcnt register.
- event_o is combinational from registers plus the current-cycle upd/strobe. Edge latency from raw change is filt_len+1 strobes.

Test Plan:
- Mode 011, filt 0, div 0, sel 3, cfg_sel_clk_i 0: toggle signal_i[3] 0→1 → event_o is a 1-cycle pulse in the first cycle raw = 1; filt_sig_o rises the next cycle.
- Mode 010, filt 3: pulse signal_i[sel] high for 3 clks → no filt_sig_o change; hold high 4 clks → filt_sig_o = 1 after the 4th clk.
- Mode 101, div 2: 6 edges → event_o pulses on edges 3 and 6; div_cnt_o sequence 1,2,0,1,2,0.
- Mode 110, arm then rising edge → event_o = 1 and held; cnt_end_i → event_o = 0; next rise while disarmed → event_o = 0; ctrl_arm_i with cnt_end_i in the same cycle → armed = 1.
- cfg_sel_clk_i 1, ls_clk_i period 10 clks, mode 000 → event_o is a 1-cycle pulse 2–3 clks after each ls_clk rise; a signal change between ls rises is not sampled.
- sel = 40 (≥ EXTSIG_NUM) → filt_sig_o stays 0. Reset asserted mid-filter count → all state 0 immediately, asynchronously.
